// File: rtl/e_gpu_data_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : e_gpu_data_mem_bridge
//  Description : OBI slave to single-port fixed-latency SRAM bridge for the
//                e-GPU data-memory master port. Every request is granted in
//                the same cycle. Requests that fall outside the SRAM window
//                are answered with an error response. Exactly one in-order
//                response is returned READ_LATENCY cycles after each grant.
//                A saturating counter tracks errored requests for debug.
//  Ports       : clk_i, rst_i                      clock, sync active-high reset
//                req_i/gnt_o/addr_i/we_i/be_i/wdata_i  OBI request channel
//                rvalid_o/rdata_o/err_o            OBI response channel
//                sram_req_o/we_o/addr_o/be_o/wdata_o, sram_rdata_i  SRAM port
//                err_cnt_o                         saturating error count
//  Revision    : 1.0 - initial release
// ============================================================================
module e_gpu_data_mem_bridge #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    MEM_SIZE_BYTE = 131072,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h0000_0000,
    parameter int                    READ_LATENCY  = 1,
    parameter int                    ERR_CNT_WIDTH = 16,
    localparam int                   AW            = $clog2(MEM_SIZE_BYTE / 4)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic                     we_i,
    input  logic [DATA_WIDTH/8-1:0]  be_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic                     rvalid_o,
    output logic [DATA_WIDTH-1:0]    rdata_o,
    output logic                     err_o,
    output logic                     sram_req_o,
    output logic                     sram_we_o,
    output logic [AW-1:0]            sram_addr_o,
    output logic [DATA_WIDTH/8-1:0]  sram_be_o,
    output logic [DATA_WIDTH-1:0]    sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]    sram_rdata_i,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    // One extra bit so the window size itself is representable even when it
    // equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] c_mem_size = (ADDR_WIDTH + 1)'(MEM_SIZE_BYTE);

    logic                  w_hs;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_last_valid;
    logic                  w_unused_offset;

    logic [READ_LATENCY-1:0]  r_valid;
    logic [READ_LATENCY-1:0]  r_is_read;
    logic [READ_LATENCY-1:0]  r_err;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    // No backpressure: any request outside reset is a handshake.
    assign w_hs  = req_i & ~rst_i;
    assign gnt_o = w_hs;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign w_offset   = addr_i - BASE_ADDR;
    assign w_in_range = ({1'b0, w_offset} < c_mem_size);

    // Byte-lane bits and bits above the window are intentionally ignored.
    assign w_unused_offset = ^{w_offset[1:0], w_offset[ADDR_WIDTH-1:AW+2]};

    assign sram_req_o   = w_hs & w_in_range;
    assign sram_we_o    = we_i;
    assign sram_addr_o  = w_offset[AW+1:2];
    assign sram_be_o    = be_i;
    assign sram_wdata_o = wdata_i;

    // Response shift register, aligned with the SRAM read latency so the
    // last stage coincides with the cycle sram_rdata_i is valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid   <= '0;
            r_is_read <= '0;
            r_err     <= '0;
        end else begin
            r_valid[0]   <= w_hs;
            r_is_read[0] <= ~we_i;
            r_err[0]     <= w_hs & ~w_in_range;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_valid[i]   <= r_valid[i-1];
                r_is_read[i] <= r_is_read[i-1];
                r_err[i]     <= r_err[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else if (w_hs && !w_in_range && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    // Gating with rst_i guarantees that a response reaching the last stage in
    // the reset cycle itself is discarded along with the rest of the flight.
    assign w_last_valid = r_valid[READ_LATENCY-1] & ~rst_i;
    assign rvalid_o     = w_last_valid;
    assign err_o        = w_last_valid & r_err[READ_LATENCY-1];
    assign rdata_o      = (w_last_valid && r_is_read[READ_LATENCY-1] && !r_err[READ_LATENCY-1])
                          ? sram_rdata_i : '0;
    assign err_cnt_o    = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/e_gpu_data_mem_bridge.md
# e_gpu_data_mem_bridge

OBI slave-to-SRAM bridge that sits directly downstream of the e-GPU data-memory OBI master port. It terminates the GPU's external data traffic on a single-port, fixed-latency SRAM macro. Every request is accepted, and out-of-range accesses are range-checked. The block returns one OBI response per granted request, in order, exactly `READ_LATENCY` cycles after the grant. It also keeps a saturating error counter for debug.

## Interface

Parameters:
- `ADDR_WIDTH`, 32, OBI byte-address width.
- `DATA_WIDTH`, 32, OBI/SRAM data width. Fixed at 32; `be` is 4 bits.
- `MEM_SIZE_BYTE`, 131072, SRAM capacity in bytes. Must be a power of two and at least 8.
- `BASE_ADDR`, 32'h0000_0000, first byte address mapped to the SRAM. Must be aligned to `MEM_SIZE_BYTE`.
- `READ_LATENCY`, 1, SRAM read latency in cycles. Legal range is 1..4.
- `ERR_CNT_WIDTH`, 16, width of the error counter.

Ports (`AW = $clog2(MEM_SIZE_BYTE/4)`):
- `clk_i` input 1: single clock. All state changes on its rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `req_i` input 1: OBI request valid.
- `gnt_o` output 1: OBI grant.
- `addr_i` input ADDR_WIDTH: OBI byte address.
- `we_i` input 1: 1 = write, 0 = read.
- `be_i` input 4: byte enables.
- `wdata_i` input 32: write data.
- `rvalid_o` output 1: OBI response valid.
- `rdata_o` output 32: read data.
- `err_o` output 1: response error flag, qualified by `rvalid_o`.
- `sram_req_o` output 1: SRAM access strobe.
- `sram_we_o` output 1: SRAM write enable.
- `sram_addr_o` output AW: SRAM word index.
- `sram_be_o` output 4: SRAM byte enables.
- `sram_wdata_o` output 32: SRAM write data.
- `sram_rdata_i` input 32: SRAM read data, valid `READ_LATENCY` cycles after a read strobe.
- `err_cnt_o` output ERR_CNT_WIDTH: saturating count of errored requests.

## Operation

Grant and range check:
- `gnt_o = req_i & ~rst_i`. Grant is combinational; there is no backpressure. Handshake = `req_i & gnt_o`.
- In range means `addr_i - BASE_ADDR < MEM_SIZE_BYTE`, computed as unsigned ADDR_WIDTH arithmetic. An address below `BASE_ADDR` wraps to a large value and is therefore out of range.
- `addr_i[1:0]` is ignored; there is no misalignment error.

SRAM drive (combinational):
- For an in-range handshake: `sram_req_o=1`, `sram_we_o=we_i`, `sram_addr_o=(addr_i-BASE_ADDR)[AW+1:2]`, `sram_be_o=be_i`, `sram_wdata_o=wdata_i`.
- For an out-of-range handshake or no handshake: `sram_req_o=0`. The other SRAM outputs are don't-care; the implementation drives them with the unguarded values.

Response pipeline:
- A shift register `READ_LATENCY` stages deep. Each stage holds `{valid, is_read, err}`.
- Stage 0 loads `{handshake, ~we_i, handshake & out_of_range}`.
- Responses are in order, one per handshake, including writes and errored requests.

Response outputs, taken from the last stage:
- `rvalid_o` = valid.
- `err_o` = valid & err.
- `rdata_o` = `sram_rdata_i` if valid & is_read & ~err; otherwise 32'h0.

Error counter:
- `err_cnt_o` increments by 1 on every out-of-range handshake, in the cycle after the handshake.
- It saturates at all-ones and clears only on reset.

Reset:
- While `rst_i` is high: all pipeline valids clear, `err_cnt_o` = 0, `gnt_o` = 0, `sram_req_o` = 0.
- The cycle after reset: `rvalid_o`=0, `err_o`=0, `rdata_o`=0, `err_cnt_o`=0.
- Reset asserted mid-operation discards all in-flight responses; no `rvalid_o` is produced for them. This is the required behaviour even though the OBI master will have been reset too.

## Timing

- Grant latency is 0 cycles (same cycle as `req_i`).
- Response latency is exactly `READ_LATENCY` cycles. A handshake at cycle N gives `rvalid_o` at cycle N+`READ_LATENCY`. This holds for reads, writes and errors.
- Throughput is 1 request/cycle sustained. Back-to-back handshakes give back-to-back `rvalid_o` pulses.
- The SRAM write takes effect at the edge ending cycle N.
- A read issued in the cycle after a write to the same word returns the new data. This is an SRAM property; the bridge adds no forwarding.
- Up to `READ_LATENCY` responses may be outstanding. No response is ever dropped or reordered.
- At `READ_LATENCY`=1 the pipeline is a single register stage. `rdata_o` is combinational from `sram_rdata_i` in the response cycle.

## Test plan

- **Basic write then read** (`READ_LATENCY`=1, `BASE_ADDR`=0):
  - Stimulus: write 32'hDEADBEEF to 0x10 with `be`=4'hF, then read 0x10.
  - Required: `sram_addr_o`=4 for both accesses. Write response has `rvalid_o`=1, `err_o`=0. Read response at N+1 returns `rdata_o`=32'hDEADBEEF.
- **Byte enables:**
  - Stimulus: write 32'h11223344 with `be`=4'b0101 over a word holding 32'hFFFFFFFF, then read it back.
  - Required: `rdata_o`=32'hFF22FF44.
- **Out of range** (`BASE_ADDR`=32'h1000_0000, `MEM_SIZE_BYTE`=131072):
  - Stimulus: read 0x1002_0000, then write 0x0FFF_FFFC.
  - Required: `sram_req_o`=0 for both. Both responses have `err_o`=1 and `rdata_o`=0. `err_cnt_o`=2.
- **Back-to-back at `READ_LATENCY`=3:**
  - Stimulus: 8 consecutive reads of words 0..7, preloaded with values 0..7.
  - Required: 8 consecutive `rvalid_o` cycles starting 3 cycles after the first grant, with `rdata_o` = 0..7 in order.
- **Reset mid-flight** (`READ_LATENCY`=4):
  - Stimulus: issue 3 reads, then assert `rst_i` for 1 cycle one cycle later.
  - Required: no `rvalid_o` ever appears for those reads. `err_cnt_o`=0. `gnt_o`=0 during reset.
- **Error counter saturation** (`ERR_CNT_WIDTH`=4):
  - Stimulus: 20 out-of-range requests.
  - Required: `err_cnt_o` stops at 4'hF, and all 20 responses have `err_o`=1.
